// File: rtl/Common.sv
// Shared enums for the training datapath.
package Common;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StDivA,
    StDivB,
    StSub,
    StDone
  } bce_state_t;

endpackage

// File: rtl/FixedPoint.sv
// Signed fixed-point (sfp) type and the constants shared by the arithmetic blocks.
package FixedPoint;

  localparam int unsigned SFP_W    = 16;
  localparam int unsigned SFP_FRAC = 8;

  typedef logic signed [SFP_W-1:0] sfp;

  localparam sfp ONE     = sfp'(1 << SFP_FRAC);
  localparam sfp HALF    = sfp'(1 << (SFP_FRAC - 1));
  localparam sfp epsilon = sfp'(1);
  localparam sfp SFP_MAX = sfp'((1 << (SFP_W - 1)) - 1);
  localparam sfp SFP_MIN = -SFP_MAX;

endpackage

// File: rtl/sfp_seq_divider.sv
// Unsigned restoring divider: (num << F) / den, one quotient bit per cycle, W+F cycles.
module sfp_seq_divider #(
  parameter int unsigned W = 16,
  parameter int unsigned F = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int unsigned N  = W + F;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [N-1:0] QMAX = {{(F + 1){1'b0}}, {(W - 1){1'b1}}};

  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  den_q, den_d;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [N-1:0]  dq_q, dq_d;

  logic [W:0]    rem_shift;
  logic [W:0]    rem_sub;
  logic          q_bit;
  logic [N-1:0]  dq_step;

  always_comb begin
    rem_shift = {rem_q, dq_q[N-1]};
    rem_sub   = rem_shift - {1'b0, den_q};
    // rem < den keeps |rem_shift - den| < 2^W, so the top bit is the borrow.
    q_bit     = ~rem_sub[W];
    dq_step   = {dq_q[N-2:0], q_bit};
  end

  always_comb begin
    cnt_d = cnt_q;
    rem_d = rem_q;
    den_d = den_q;
    dq_d  = dq_q;
    if (start) begin
      cnt_d = CW'(N);
      rem_d = '0;
      den_d = den;
      dq_d  = {num, {F{1'b0}}};
    end else if (busy) begin
      cnt_d = cnt_q - CW'(1);
      rem_d = q_bit ? rem_sub[W-1:0] : rem_shift[W-1:0];
      dq_d  = dq_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      rem_q <= '0;
      den_q <= '0;
      dq_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      den_q <= den_d;
      dq_q  <= dq_d;
    end
  end

  // quotient is the final, saturated value during the cycle that done is high.
  always_comb begin
    busy     = (cnt_q != '0);
    done     = (cnt_q == CW'(1));
    quotient = (dq_step > QMAX) ? QMAX[W-1:0] : dq_step[W-1:0];
  end

endmodule

// File: rtl/bce_grad_unit.sv
// Binary-cross-entropy gradient (1-y)/(1-p') - y/p' using one shared sequential divider.
module bce_grad_unit
  import FixedPoint::*;
  import Common::*;
#(
  parameter int unsigned W = SFP_W,
  parameter int unsigned F = SFP_FRAC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] prediction,
  input  logic [W-1:0] expected,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] grad
);

  localparam int ONE_I = 1 << F;
  localparam int MAX_I = (1 << (W - 1)) - 1;

  localparam logic signed [W:0] ONE_X  = (W + 1)'(ONE_I);
  localparam logic signed [W:0] EPS_X  = (W + 1)'(epsilon);
  localparam logic signed [W:0] HI_X   = ONE_X - EPS_X;
  localparam logic signed [W:0] ZERO_X = '0;
  localparam logic signed [W:0] MAX_X  = (W + 1)'(MAX_I);
  localparam logic signed [W:0] MIN_X  = -MAX_X;
  localparam logic [W-1:0]      ONE_W  = W'(ONE_I);

  bce_state_t state_q, state_d;

  logic [W-1:0] p_q, y_q;
  logic [W-1:0] pc_q, yc_q;
  logic [W-1:0] qa_q, qb_q;
  logic [W-1:0] grad_q;

  logic signed [W:0] p_sum, pc_x, y_x, yc_x, diff, diff_sat;
  logic [W-1:0] pc_w, yc_w;

  logic         div_start, div_busy, div_done;
  logic [W-1:0] div_num, div_den, div_q;
  logic         div_fin;

  // Clamps, widened by one bit so p + epsilon cannot wrap.
  always_comb begin
    p_sum = $signed({p_q[W-1], p_q}) + EPS_X;
    if (p_sum < EPS_X)     pc_x = EPS_X;
    else if (p_sum > HI_X) pc_x = HI_X;
    else                   pc_x = p_sum;
    y_x = $signed({y_q[W-1], y_q});
    if (y_x < ZERO_X)      yc_x = ZERO_X;
    else if (y_x > ONE_X)  yc_x = ONE_X;
    else                   yc_x = y_x;
    pc_w = W'(pc_x);
    yc_w = W'(yc_x);
  end

  always_comb begin
    diff = $signed({qb_q[W-1], qb_q}) - $signed({qa_q[W-1], qa_q});
    if (diff > MAX_X)      diff_sat = MAX_X;
    else if (diff < MIN_X) diff_sat = MIN_X;
    else                   diff_sat = diff;
  end

  assign div_fin = div_busy && div_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StPrep;
      StPrep:  state_d = StDivA;
      StDivA:  if (div_fin) state_d = StDivB;
      StDivB:  if (div_fin) state_d = StSub;
      StSub:   state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    grad      = grad_q;
    div_start = 1'b0;
    div_num   = '0;
    div_den   = '0;
    if (state_q == StPrep) begin
      div_start = 1'b1;
      div_num   = yc_w;
      div_den   = pc_w;
    end else if (state_q == StDivA && div_fin) begin
      div_start = 1'b1;
      div_num   = ONE_W - yc_q;
      div_den   = ONE_W - pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= '0;
      y_q    <= '0;
      pc_q   <= '0;
      yc_q   <= '0;
      qa_q   <= '0;
      qb_q   <= '0;
      grad_q <= '0;
    end else begin
      if (state_q == StIdle && in_valid) begin
        p_q <= prediction;
        y_q <= expected;
      end
      if (state_q == StPrep) begin
        pc_q <= pc_w;
        yc_q <= yc_w;
      end
      if (state_q == StDivA && div_fin) qa_q <= div_q;
      if (state_q == StDivB && div_fin) qb_q <= div_q;
      if (state_q == StSub) grad_q <= W'(diff_sat);
    end
  end

  sfp_seq_divider #(
    .W(W),
    .F(F)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .num     (div_num),
    .den     (div_den),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_q)
  );

endmodule
